// File: rtl/keypad_pkg.sv
// Shared key codes, entry FSM states and helpers for the keypad entry controller.
package keypad_pkg;

    localparam logic [3:0] KC_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KC_ENTER     = 4'hA;
    localparam logic [3:0] KC_CLEAR     = 4'hB;
    localparam logic [3:0] KC_NONE      = 4'hF;

    localparam logic [3:0] COL_INIT = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_HOLD
    } entry_state_t;

    // Snapshot bit index is col*4+row; anything outside the wired keys decodes to KC_NONE.
    function automatic logic [3:0] onehot_to_keycode(input logic [15:0] bits);
        logic [3:0] code;
        case (bits)
            16'h0008: code = 4'h0;
            16'h0080: code = 4'h1;
            16'h0040: code = 4'h2;
            16'h0020: code = 4'h3;
            16'h0800: code = 4'h4;
            16'h0400: code = 4'h5;
            16'h0200: code = 4'h6;
            16'h8000: code = 4'h7;
            16'h4000: code = 4'h8;
            16'h2000: code = 4'h9;
            16'h0010: code = KC_ENTER;
            16'h1000: code = KC_CLEAR;
            default:  code = KC_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scan, full-frame snapshot, debounce and press-edge detection for a 4x4 keypad.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic        key_evt,
    output logic [15:0] key_bits
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic [15:0]      snap_acc;
    logic [15:0]      prev_snap;
    logic [CNT_W-1:0] match_cnt;
    logic [15:0]      snap_full;
    logic [CNT_W-1:0] match_next;
    logic             dwell_end;
    logic             frame_end;
    logic             accept;

    function automatic logic is_onehot(input logic [15:0] v);
        return (v != 16'h0) && ((v & (v - 16'h1)) == 16'h0);
    endfunction

    always_comb begin
        dwell_end = (div_cnt == DIV_W'(SCAN_DIV - 1));
        frame_end = dwell_end && (col_idx == 2'd3);
        snap_full = snap_acc;
        snap_full[{col_idx, 2'b00} +: 4] = ~row_n;
        if (snap_full == prev_snap)
            match_next = (match_cnt == CNT_W'(DEBOUNCE_SCANS)) ? match_cnt : match_cnt + 1'b1;
        else
            match_next = CNT_W'(1);
        accept = (match_next >= CNT_W'(DEBOUNCE_SCANS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            col_idx   <= 2'd0;
            col_n     <= COL_INIT;
            snap_acc  <= '0;
            prev_snap <= '0;
            match_cnt <= '0;
            key_bits  <= '0;
            key_evt   <= 1'b0;
        end else begin
            key_evt <= 1'b0;
            if (dwell_end) begin
                div_cnt  <= '0;
                col_idx  <= col_idx + 2'd1;
                col_n    <= {col_n[2:0], col_n[3]};
                snap_acc <= snap_full;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            // Only a complete four-column frame takes part in debouncing.
            if (frame_end) begin
                prev_snap <= snap_full;
                match_cnt <= match_next;
                if (accept && (snap_full != key_bits)) begin
                    key_bits <= snap_full;
                    key_evt  <= (key_bits == 16'h0) && is_onehot(snap_full);
                end
            end
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad-to-BCD entry controller: scanner, key decode, entry FSM and valid/ready output.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int NUM_DIGITS     = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [3:0]                        row_n,
    output logic [3:0]                        col_n,
    output logic [4*NUM_DIGITS-1:0]           out_data,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   out_count,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              key_pulse,
    output logic [3:0]                        key_code,
    output logic                              err_pulse
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);

    logic          key_evt;
    logic [15:0]   key_bits;
    entry_state_t  state_q, state_d;
    logic [DW-1:0] data_d;
    logic [CW-1:0] count_d;
    logic          err_d;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scanner (
        .clk      (clk),
        .rst      (rst),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_evt  (key_evt),
        .key_bits (key_bits)
    );

    assign out_valid = (state_q == ST_HOLD);

    always_comb begin
        state_d = state_q;
        data_d  = out_data;
        count_d = out_count;
        err_d   = 1'b0;
        if (state_q == ST_HOLD) begin
            // A handshake in the same cycle as a key event wins; the key is dropped silently.
            if (out_ready) begin
                state_d = ST_IDLE;
                data_d  = '0;
                count_d = '0;
            end else if (key_pulse) begin
                err_d = 1'b1;
            end
        end else if (key_pulse) begin
            if (key_code <= KC_DIGIT_MAX) begin
                if (out_count < CW'(NUM_DIGITS)) begin
                    data_d  = {out_data[DW-5:0], key_code};
                    count_d = out_count + 1'b1;
                    state_d = ST_ENTRY;
                end else begin
                    err_d = 1'b1;
                end
            end else if (key_code == KC_ENTER) begin
                if (out_count != '0) state_d = ST_HOLD;
                else                 err_d   = 1'b1;
            end else if (key_code == KC_CLEAR) begin
                state_d = ST_IDLE;
                data_d  = '0;
                count_d = '0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            out_data  <= '0;
            out_count <= '0;
            key_pulse <= 1'b0;
            key_code  <= 4'h0;
            err_pulse <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_data  <= data_d;
            out_count <= count_d;
            err_pulse <= err_d;
            key_pulse <= key_evt;
            if (key_evt) key_code <= onehot_to_keycode(key_bits);
        end
    end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench for keypad_entry_ctrl with a simulated key matrix and a digit-queue reference model.
module tb_keypad_entry_ctrl;

    localparam int SD = 4;
    localparam int DB = 2;
    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [11:0] out_data;
    logic [1:0]  out_count;
    logic        out_valid;
    logic        out_ready;
    logic        key_pulse;
    logic [3:0]  key_code;
    logic        err_pulse;

    logic [15:0] pressed;
    logic [3:0]  keymap [16];
    int          model_q[$];
    bit          model_valid;
    int          n_tests;
    int          n_fail;

    keypad_entry_ctrl #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DB),
        .NUM_DIGITS     (ND)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .out_data  (out_data),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .key_pulse (key_pulse),
        .key_code  (key_code),
        .err_pulse (err_pulse)
    );

    always #5 clk = ~clk;

    // Matrix: a pressed key at (col,row) pulls row low while its column is driven low.
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col_n[c] && pressed[c*4+r]) row_n[r] = 1'b0;
    end

    function automatic logic [11:0] exp_data();
        logic [11:0] d = 12'h0;
        foreach (model_q[i]) d = {d[7:0], 4'(model_q[i])};
        return d;
    endfunction

    function automatic bit model_key(input logic [3:0] code);
        if (model_valid) return 1'b1;
        if (code <= 4'h9) begin
            if (model_q.size() < ND) begin
                model_q.push_back(int'(code));
                return 1'b0;
            end
            return 1'b1;
        end
        if (code == 4'hA) begin
            if (model_q.size() > 0) begin
                model_valid = 1'b1;
                return 1'b0;
            end
            return 1'b1;
        end
        if (code == 4'hB) begin
            model_q.delete();
            return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_pulse(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (key_pulse) seen = 1'b1;
        end
    endtask

    task automatic settle(input string tag);
        int pulses = 0;
        int errs   = 0;
        pressed = '0;
        repeat (100) begin
            @(negedge clk);
            if (key_pulse) pulses++;
            if (err_pulse) errs++;
        end
        n_tests++;
        if (pulses != 0 || errs != 0) begin
            n_fail++;
            $display("FAIL %s_release: key_pulse=%0d err_pulse=%0d, required 0 and 0", tag, pulses, errs);
        end
    endtask

    task automatic do_key(input int b);
        bit seen;
        bit e;
        pressed    = '0;
        pressed[b] = 1'b1;
        wait_pulse(seen);
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL key%0d_pulse: no key_pulse within bound", b);
        end else begin
            if (key_code !== keymap[b]) begin
                n_fail++;
                $display("FAIL key%0d_code: got %h, required %h", b, key_code, keymap[b]);
            end
            e = model_key(keymap[b]);
            @(negedge clk);
            n_tests++;
            if (err_pulse !== e || out_data !== exp_data() || out_count !== 2'(model_q.size())
                || out_valid !== model_valid || key_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL key%0d_effect: err=%b data=%h cnt=%0d vld=%b kp=%b, required err=%b data=%h cnt=%0d vld=%b kp=0",
                         b, err_pulse, out_data, out_count, out_valid, key_pulse,
                         e, exp_data(), model_q.size(), model_valid);
            end
        end
        settle($sformatf("key%0d", b));
    endtask

    task automatic do_handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        model_q.delete();
        model_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 12'h0 || out_count !== 2'd0) begin
            n_fail++;
            $display("FAIL handshake: vld=%b data=%h cnt=%0d, required 0 000 0", out_valid, out_data, out_count);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_tests++;
        if (col_n !== 4'b1110 || out_data !== 12'h0 || out_count !== 2'd0 || out_valid !== 1'b0
            || key_pulse !== 1'b0 || key_code !== 4'h0 || err_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: col=%b data=%h cnt=%0d vld=%b kp=%b kc=%h err=%b, required 1110 000 0 0 0 0 0",
                     tag, col_n, out_data, out_count, out_valid, key_pulse, key_code, err_pulse);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        logic [3:0] exp_col;
        rst = 1'b1;
        out_ready = 1'b0;
        pressed = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        rst = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            exp_col = 4'hF & ~(4'h1 << ((k / SD) % 4));
            if (col_n !== exp_col) begin
                if (bad == 0) $display("FAIL col_rotation: cycle %0d col_n=%b, required %b", k, col_n, exp_col);
                bad++;
            end
        end
        n_tests++;
        if (bad != 0) n_fail++;
    endtask

    task automatic test_entry();
        int changes = 0;
        do_key(7);
        do_key(6);
        do_key(5);
        do_key(4);
        n_tests++;
        if (out_data !== 12'h123 || out_count !== 2'd3 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL entry_123: data=%h cnt=%0d vld=%b, required 123 3 1", out_data, out_count, out_valid);
        end
        repeat (50) begin
            @(negedge clk);
            if (out_data !== 12'h123 || out_count !== 2'd3 || out_valid !== 1'b1) changes++;
        end
        n_tests++;
        if (changes != 0) begin
            n_fail++;
            $display("FAIL hold_stable: %0d unstable cycles, required 0", changes);
        end
        do_handshake();
    endtask

    task automatic test_bounce();
        int pulses = 0;
        for (int s = 0; s < 6; s++) begin
            pressed = (s % 2 == 0) ? 16'h0008 : 16'h0000;
            repeat (16) begin
                @(negedge clk);
                if (key_pulse) pulses++;
            end
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL bounce_pulses: %0d pulses while bouncing, required 0", pulses);
        end
        do_key(3);
    endtask

    task automatic test_overflow();
        do_key(12);
        do_key(11);
        do_key(10);
        do_key(9);
        do_key(13);
        n_tests++;
        if (out_data !== 12'h456 || out_count !== 2'd3) begin
            n_fail++;
            $display("FAIL overflow_keep: data=%h cnt=%0d, required 456 3", out_data, out_count);
        end
        do_key(12);
    endtask

    task automatic test_empty_and_multi();
        int pulses = 0;
        do_key(4);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_enter_valid: vld=%b, required 0", out_valid);
        end
        pressed = 16'h00C0;
        repeat (120) begin
            @(negedge clk);
            if (key_pulse) pulses++;
        end
        pressed = 16'h0000;
        repeat (100) begin
            @(negedge clk);
            if (key_pulse) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL multi_key: %0d pulses, required 0", pulses);
        end
        do_key(7);
        do_key(12);
    endtask

    task automatic test_hold_handshake();
        bit seen;
        do_key(14);
        do_key(4);
        pressed = 16'h4000;
        wait_pulse(seen);
        out_ready = 1'b1;
        n_tests++;
        if (!seen || key_code !== 4'h8) begin
            n_fail++;
            $display("FAIL hs_key_pulse: seen=%b code=%h, required 1 8", seen, key_code);
        end
        @(negedge clk);
        out_ready = 1'b0;
        model_q.delete();
        model_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 12'h0 || out_count !== 2'd0 || err_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_collision: vld=%b data=%h cnt=%0d err=%b, required 0 000 0 0",
                     out_valid, out_data, out_count, err_pulse);
        end
        settle("hs");
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        do_key(3);
        do_key(7);
        do_key(6);
        n_tests++;
        if (out_data !== 12'h012) begin
            n_fail++;
            $display("FAIL pre_reset_data: data=%h, required 012", out_data);
        end
        while (col_n !== 4'b1101 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        model_valid = 1'b0;
        check_reset_outputs("mid_reset");
    endtask

    task automatic test_random();
        int b;
        for (int i = 0; i < 20; i++) begin
            if (model_valid && $urandom_range(0, 1) == 1) do_handshake();
            b = int'($urandom_range(0, 15));
            do_key(b);
        end
        if (model_valid) do_handshake();
    endtask

    initial begin
        keymap = '{4'hF, 4'hF, 4'hF, 4'h0, 4'hA, 4'h3, 4'h2, 4'h1,
                   4'hF, 4'h6, 4'h5, 4'h4, 4'hB, 4'h9, 4'h8, 4'h7};
        n_tests = 0;
        n_fail = 0;
        model_valid = 1'b0;
        rst = 1'b1;
        out_ready = 1'b0;
        pressed = '0;
        test_reset();
        test_entry();
        test_bounce();
        test_overflow();
        test_empty_and_multi();
        test_hold_handshake();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
